// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (registered read,
// read-before-write) between the 6502 CPU and a DMA requester.
// The CPU has fixed priority. A bounded-wait counter forces one DMA access
// after STARVE_LIMIT consecutive ungranted DMA request cycles.
// Optional feature macro: RAM_ARB_WPROT_EN. When it is defined, CPU writes at
// or above WPROT_BASE are suppressed and flagged on cpu_wprot_err.
module ram_arbiter #(
  parameter int                    ADDR_WIDTH   = 14,
  parameter int                    STARVE_LIMIT = 8,
  parameter logic [ADDR_WIDTH-1:0] WPROT_BASE   = 14'h2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [7:0]            cpu_din,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [7:0]            cpu_dout,
`ifdef RAM_ARB_WPROT_EN
  output logic                  cpu_wprot_err,
`endif
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_we,
  input  logic [7:0]            dma_din,
  output logic                  dma_ack,
  output logic                  dma_rvalid,
  output logic [7:0]            dma_dout,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_w_en,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // Saturating increment used by the starvation counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] lim);
    return (val >= lim) ? lim : val + 8'd1;
  endfunction

  owner_t                  owner_p0;
  owner_t                  owner_p1;
  logic [7:0]              starve_cnt;
  logic [7:0]              starve_nxt;
  logic                    force_dma;
  logic                    grant_cpu;
  logic                    grant_dma;
  logic                    wprot_hit_p0;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic [7:0]              cpu_hold;
  logic [7:0]              dma_hold;

  // ---- Stage p0: grant decision and RAM request (combinational) ----

  // Arbitrate: forced DMA beats CPU, CPU beats DMA otherwise; nothing during reset.
  always_comb begin
    force_dma = 1'b0;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    owner_p0  = OWN_NONE;
    if (!rst) begin
      force_dma = (starve_cnt == LIMIT) && dma_req;
      grant_cpu = cpu_req && !force_dma;
      grant_dma = dma_req && !grant_cpu;
      if (grant_cpu)      owner_p0 = OWN_CPU;
      else if (grant_dma) owner_p0 = OWN_DMA;
    end
  end

  // Starvation counter next value: clear on DMA grant or idle DMA, else count up.
  always_comb begin
    starve_nxt = 8'd0;
    if (dma_req && !grant_dma) starve_nxt = sat_inc(starve_cnt, LIMIT);
  end

`ifdef RAM_ARB_WPROT_EN
  // Detect a granted CPU write into the protected window.
  always_comb begin
    wprot_hit_p0 = 1'b0;
    if (grant_cpu && cpu_we && (cpu_addr >= WPROT_BASE)) wprot_hit_p0 = 1'b1;
  end
`else
  logic unused_wprot_base;
  assign unused_wprot_base = ^WPROT_BASE;

  // Without the protection feature no CPU write is ever suppressed.
  always_comb begin
    wprot_hit_p0 = 1'b0;
  end
`endif

  // Drive the RAM from the granted requester; idle keeps the last address.
  always_comb begin
    ram_address = addr_hold;
    ram_din     = dma_din;
    ram_w_en    = 1'b0;
    if (rst) begin
      ram_address = '0;
    end else if (grant_cpu) begin
      ram_address = cpu_addr;
      ram_din     = cpu_din;
      ram_w_en    = cpu_we && !wprot_hit_p0;
    end else if (grant_dma) begin
      ram_address = dma_addr;
      ram_din     = dma_din;
      ram_w_en    = dma_we;
    end
  end

  // Handshake outputs for the current cycle.
  always_comb begin
    cpu_stall = !rst && cpu_req && force_dma;
    dma_ack   = grant_dma;
  end

  // ---- Stage p1: owner tag registered at grant, read data returns ----

  // Owner tag register; reset squashes any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) owner_p1 <= OWN_NONE;
    else     owner_p1 <= owner_p0;
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt <= 8'd0;
    else     starve_cnt <= starve_nxt;
  end

  // Remember the address presented so idle cycles keep it stable.
  always_ff @(posedge clk) begin
    if (rst) addr_hold <= '0;
    else     addr_hold <= ram_address;
  end

  // Route returning read data to the owner; reset masks a pending pulse.
  always_comb begin
    cpu_rvalid = !rst && (owner_p1 == OWN_CPU);
    dma_rvalid = !rst && (owner_p1 == OWN_DMA);
    cpu_dout   = cpu_rvalid ? ram_dout : cpu_hold;
    dma_dout   = dma_rvalid ? ram_dout : dma_hold;
  end

  // Keep each requester's last read data until its next rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_hold <= 8'h00;
      dma_hold <= 8'h00;
    end else begin
      if (cpu_rvalid) cpu_hold <= ram_dout;
      if (dma_rvalid) dma_hold <= ram_dout;
    end
  end

`ifdef RAM_ARB_WPROT_EN
  logic wprot_p1;

  // Carry the protection hit alongside the CPU read it belongs to.
  always_ff @(posedge clk) begin
    if (rst) wprot_p1 <= 1'b0;
    else     wprot_p1 <= wprot_hit_p0;
  end

  // Error pulse coincides with the CPU rvalid of the suppressed write.
  always_comb begin
    cpu_wprot_err = cpu_rvalid && wprot_p1;
  end
`endif

endmodule
